reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits (multiple of 8).
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter NUM_RD, default 2, meaning read port count (1..4).
REQ-004 The block SHALL have parameter NUM_WR, default 2, meaning write port count (1..2).
REQ-005 The block SHALL have parameter INIT_MODE, default 1, meaning reset fill value: 0 = all zero, 1 = entry i holds i.
REQ-006 The block SHALL have parameter ZERO_REG, default 1, meaning 1 = entry 0 reads 0 and ignores writes.
REQ-007 The block SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write data forwarded to reads.
REQ-008 The block SHALL have port clk, input, width 1, meaning the single clock; all state updates on its rising edge.
REQ-009 The block SHALL have port rst_n, input, width 1, meaning reset, asynchronous and active-low.
REQ-010 The block SHALL have port rd_addr, input, width NUM_RD*ADDR_W, meaning packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-011 The block SHALL have port rd_data, output, width NUM_RD*DATA_W, meaning packed read data.
REQ-012 The block SHALL have port wr_en, input, width NUM_WR, meaning per-port write enable.
REQ-013 The block SHALL have port wr_addr, input, width NUM_WR*ADDR_W, meaning packed write addresses.
REQ-014 The block SHALL have port wr_data, input, width NUM_WR*DATA_W, meaning packed write data.
REQ-015 The block SHALL have port wr_be, input, width NUM_WR*DATA_W/8, meaning per-port byte enables.
REQ-016 The block SHALL have port ready, output, width 1, meaning initialisation complete; accesses valid.
REQ-017 The block SHALL have port wr_conflict, output, width 1, meaning one-cycle pulse when both write ports hit the same address.

Function
REQ-018 The FSM SHALL have states INIT and RUN; INIT writes the fill value to entry init_cnt each cycle, init_cnt counting 0..DEPTH-1.
REQ-019 The FSM SHALL go INIT->RUN on the edge that writes entry DEPTH-1; ready SHALL rise on that edge (DEPTH cycles after rst_n deasserts).
REQ-020 In INIT, wr_en SHALL be ignored and rd_data SHALL read 0.
REQ-021 In RUN, reads SHALL be combinational: rd_data port k = entry rd_addr port k, with no clock latency.
REQ-022 In RUN, a write SHALL update only the bytes with wr_be set, on the rising clk edge with wr_en set.
REQ-023 If both ports write the same address, port 1 SHALL win on each byte both enable, other bytes SHALL merge, and wr_conflict SHALL pulse the following cycle.
REQ-024 With BYPASS=1, a read address equal to an enabled write address SHALL return the post-write merged value in the same cycle (port 1 over port 0).
REQ-025 With ZERO_REG=1, address 0 SHALL read 0 always, including bypass; writes to it SHALL be dropped, and SHALL NOT raise wr_conflict.
REQ-026 Out-of-range parameters SHALL stop elaboration with an error.

Reset
REQ-027 Assertion of rst_n SHALL immediately set the state to INIT, init_cnt to 0, ready to 0 and wr_conflict to 0, with no clock needed.
REQ-028 Reset asserted mid-INIT or mid-RUN SHALL restart the full DEPTH-cycle fill; array contents SHALL NOT be async-reset.

Structure
REQ-029 State encoding (INIT/RUN) and the parameter range limits SHALL live in the shared package regfile_pkg.
REQ-030 Byte-merge and write-priority logic SHALL be one sub-module, regfile_wmerge, reused by the write path and the bypass path.

Verification
REQ-031 The bench SHALL cover reset fill: deassert rst_n, INIT_MODE=1 -> ready=1 after exactly 32 cycles, and rd_addr=9 reads 9.
REQ-032 The bench SHALL cover byte write: write 0xAABBCCDD to r5, then wr_be=0010 with data 0x00001100 -> r5 reads 0xAABB11DD.
REQ-033 The bench SHALL cover a write collision: port 0 writes r7=0x11111111 with be=1111 and port 1 writes r7=0x22222222 with be=0011 -> r7 = 0x11112222, and wr_conflict is high one cycle.
REQ-034 The bench SHALL cover bypass: write r3=0x5 while rd_addr0=3 in the same cycle -> rd_data0=0x5 before the edge; with BYPASS=0, the old value is read.
REQ-035 The bench SHALL cover the zero register: write r0=0xFFFFFFFF -> r0 reads 0, with no wr_conflict even when both ports target r0.
REQ-036 The bench SHALL cover mid-run reset: pulse rst_n low in RUN -> ready drops at once, reads return 0 and wr_en is ignored until 32 cycles after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and parameter limits for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

  localparam int RD_PORTS_MIN = 1;
  localparam int RD_PORTS_MAX = 4;
  localparam int WR_PORTS_MIN = 1;
  localparam int WR_PORTS_MAX = 2;
  localparam int ADDR_W_MIN   = 1;
  localparam int ADDR_W_MAX   = 16;

endpackage

// File: rtl/regfile_wmerge.sv
// Byte-enable merge of all write ports onto one target entry; later ports win on shared bytes.
module regfile_wmerge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_WR = 2
) (
  input  logic [ADDR_W-1:0]          tgt_addr,
  input  logic [DATA_W-1:0]          base_data,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic [NUM_WR*DATA_W/8-1:0] wr_be,
  output logic [DATA_W-1:0]          merged_data,
  output logic                       hit
);

  localparam int NB = DATA_W / 8;

  always_comb begin
    merged_data = base_data;
    hit         = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == tgt_addr)) begin
        hit = 1'b1;
        for (int b = 0; b < NB; b++) begin
          if (wr_be[p*NB + b]) begin
            merged_data[b*8 +: 8] = wr_data[p*DATA_W + b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with self-initialising fill, byte enables,
// write-collision detection and optional same-cycle write forwarding.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter int INIT_MODE = 1,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic [NUM_WR*DATA_W/8-1:0] wr_be,
  output logic                       ready,
  output logic                       wr_conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  if ((NUM_RD < RD_PORTS_MIN) || (NUM_RD > RD_PORTS_MAX)) begin : g_bad_num_rd
    $error("reg_file_mp: NUM_RD out of range");
  end
  if ((NUM_WR < WR_PORTS_MIN) || (NUM_WR > WR_PORTS_MAX)) begin : g_bad_num_wr
    $error("reg_file_mp: NUM_WR out of range");
  end
  if ((ADDR_W < ADDR_W_MIN) || (ADDR_W > ADDR_W_MAX)) begin : g_bad_addr_w
    $error("reg_file_mp: ADDR_W out of range");
  end
  if ((DATA_W < 8) || ((DATA_W % 8) != 0)) begin : g_bad_data_w
    $error("reg_file_mp: DATA_W must be a non-zero multiple of 8");
  end
  if ((INIT_MODE < 0) || (INIT_MODE > 1)) begin : g_bad_init_mode
    $error("reg_file_mp: INIT_MODE must be 0 or 1");
  end
  if ((ZERO_REG < 0) || (ZERO_REG > 1)) begin : g_bad_zero_reg
    $error("reg_file_mp: ZERO_REG must be 0 or 1");
  end
  if ((BYPASS < 0) || (BYPASS > 1)) begin : g_bad_bypass
    $error("reg_file_mp: BYPASS must be 0 or 1");
  end

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              ready_q, ready_d;
  logic              conflict_q, conflict_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              run;
  logic [NUM_WR-1:0] wr_en_eff;
  logic              wr_conflict_now;
  logic [DATA_W-1:0] fill_val;

  logic [ADDR_W-1:0] wr_tgt    [NUM_WR];
  logic [DATA_W-1:0] wr_merged [NUM_WR];
  logic [NUM_WR-1:0] wr_hit;

  assign run      = (state_q == ST_RUN);
  assign fill_val = (INIT_MODE == 1) ? DATA_W'(init_cnt_q) : '0;

  // Writes outside RUN and writes to a hardwired-zero entry never reach the array.
  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr_en
    assign wr_tgt[gi]    = wr_addr[gi*ADDR_W +: ADDR_W];
    assign wr_en_eff[gi] = run && wr_en[gi] &&
                           !((ZERO_REG == 1) && (wr_tgt[gi] == '0));
  end

  if (NUM_WR == 2) begin : g_conflict
    assign wr_conflict_now = wr_en_eff[0] && wr_en_eff[1] && (wr_tgt[0] == wr_tgt[1]);
  end else begin : g_no_conflict
    assign wr_conflict_now = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ready_d    = ready_q;
    conflict_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (&init_cnt_q) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        conflict_d = wr_conflict_now;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
      conflict_q <= conflict_d;
    end
  end

  // Each write port computes the fully merged entry, so colliding ports store identical values.
  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr_path
    regfile_wmerge #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_wmerge (
      .tgt_addr    (wr_tgt[gi]),
      .base_data   (mem_q[wr_tgt[gi]]),
      .wr_en       (wr_en_eff),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_be       (wr_be),
      .merged_data (wr_merged[gi]),
      .hit         (wr_hit[gi])
    );
  end

  // Array has no reset; the fill sequence rewrites every entry after each reset release.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[init_cnt_q] <= fill_val;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_hit[p]) begin
          mem_q[wr_tgt[p]] <= wr_merged[p];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_path
    logic [ADDR_W-1:0] rd_tgt;
    logic [DATA_W-1:0] rd_merged;
    logic              rd_hit;
    logic [DATA_W-1:0] rd_val;

    assign rd_tgt = rd_addr[gi*ADDR_W +: ADDR_W];

    regfile_wmerge #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_bypass (
      .tgt_addr    (rd_tgt),
      .base_data   (mem_q[rd_tgt]),
      .wr_en       (wr_en_eff),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_be       (wr_be),
      .merged_data (rd_merged),
      .hit         (rd_hit)
    );

    always_comb begin
      rd_val = mem_q[rd_tgt];
      if ((BYPASS == 1) && rd_hit) begin
        rd_val = rd_merged;
      end
      if (!run || ((ZERO_REG == 1) && (rd_tgt == '0))) begin
        rd_val = '0;
      end
    end

    assign rd_data[gi*DATA_W +: DATA_W] = rd_val;
  end

  assign ready       = ready_q;
  assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised check of reg_file_mp (bypass and non-bypass builds) against an array-based model.
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 32;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data_b1, rd_data_b0;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic [NW*4-1:0]   wr_be;
  logic              ready_b1, ready_b0, conf_b1, conf_b0;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  reg_file_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
    .INIT_MODE(1), .ZERO_REG(1), .BYPASS(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .ready(ready_b1), .wr_conflict(conf_b1)
  );

  reg_file_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
    .INIT_MODE(1), .ZERO_REG(1), .BYPASS(0)
  ) u_dut_nobyp (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .ready(ready_b0), .wr_conflict(conf_b0)
  );

  always #5 clk = ~clk;

  // Reference model: plain array plus ready/conflict flags.
  logic [31:0] m_mem [DEPTH];
  bit          m_ready = 1'b0;
  int          m_cnt   = 0;
  bit          m_conf  = 1'b0;

  function automatic int wa(int p);
    return int'(wr_addr[p*AW +: AW]);
  endfunction

  function automatic int ra(int k);
    return int'(rd_addr[k*AW +: AW]);
  endfunction

  function automatic logic [31:0] exp_rd(int a, bit byp);
    logic [31:0] v;
    if (!m_ready || a == 0) return 32'h0;
    v = m_mem[a];
    if (byp) begin
      for (int p = 0; p < NW; p++) begin
        if (wr_en[p] && wa(p) == a) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_be[p*4 + b]) v[b*8 +: 8] = wr_data[p*DW + b*8 +: 8];
          end
        end
      end
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      m_conf  = 1'b0;
    end else if (!m_ready) begin
      m_mem[m_cnt] = m_cnt;
      if (m_cnt == DEPTH - 1) m_ready = 1'b1;
      else m_cnt++;
      m_conf = 1'b0;
    end else begin
      m_conf = (wr_en == 2'b11) && (wa(0) == wa(1)) && (wa(0) != 0);
      for (int p = 0; p < NW; p++) begin
        if (wr_en[p] && wa(p) != 0) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_be[p*4 + b]) m_mem[wa(p)][b*8 +: 8] = wr_data[p*DW + b*8 +: 8];
          end
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready", 32'(ready_b1), 32'(m_ready));
      chk("ready_nobyp", 32'(ready_b0), 32'(m_ready));
      chk("conflict", 32'(conf_b1), 32'(m_conf));
      chk("conflict_nobyp", 32'(conf_b0), 32'(m_conf));
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("rd%0d", k), rd_data_b1[k*DW +: DW], exp_rd(ra(k), 1'b1));
        chk($sformatf("rd%0d_nobyp", k), rd_data_b0[k*DW +: DW], exp_rd(ra(k), 1'b0));
      end
    end
  end

  task automatic idle();
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    wr_be   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(int p, int a, logic [31:0] d, logic [3:0] be);
    wr_en[p]              = 1'b1;
    wr_addr[p*AW +: AW]   = AW'(a);
    wr_data[p*DW +: DW]   = d;
    wr_be[p*4 +: 4]       = be;
  endtask

  task automatic set_rd(int k, int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic rand_cycle();
    int a0, a1;
    wr_en = 2'($urandom);
    a0 = $urandom_range(0, DEPTH - 1);
    a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, 7);
    wr_addr[0 +: AW]  = AW'(a0);
    wr_addr[AW +: AW] = AW'(a1);
    wr_data = {$urandom, $urandom};
    wr_be   = 8'($urandom);
    for (int k = 0; k < NR; k++) begin
      if ($urandom_range(0, 1) == 1) set_rd(k, (k == 0) ? a0 : a1);
      else set_rd(k, $urandom_range(0, DEPTH - 1));
    end
  endtask

  task automatic wait_ready(string name);
    int n;
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (ready_b1) begin
        n = c;
        break;
      end
    end
    chk(name, 32'(n), 32'd32);
  endtask

  initial begin
    rd_addr = '0;
    idle();
    #3 rst_n = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready("fill_cycles");

    // reset fill contents
    set_rd(0, 9);
    set_rd(1, 31);
    @(negedge clk);
    chk("fill_r9", rd_data_b1[0 +: DW], 32'd9);
    chk("fill_r31", rd_data_b1[DW +: DW], 32'd31);
    step();

    // byte write
    set_wr(0, 5, 32'hAABBCCDD, 4'hF);
    set_rd(0, 5);
    @(negedge clk);
    chk("r5_full_bypass", rd_data_b1[0 +: DW], 32'hAABBCCDD);
    step();
    idle();
    set_wr(0, 5, 32'h00001100, 4'b0010);
    @(negedge clk);
    chk("r5_byte_bypass", rd_data_b1[0 +: DW], 32'hAABB11DD);
    chk("r5_byte_nobyp_old", rd_data_b0[0 +: DW], 32'hAABBCCDD);
    step();
    idle();
    @(negedge clk);
    chk("r5_byte", rd_data_b1[0 +: DW], 32'hAABB11DD);
    chk("r5_byte_nobyp", rd_data_b0[0 +: DW], 32'hAABB11DD);
    step();

    // write collision
    set_wr(0, 7, 32'h11111111, 4'hF);
    set_wr(1, 7, 32'h22222222, 4'b0011);
    set_rd(0, 7);
    @(negedge clk);
    chk("coll_bypass", rd_data_b1[0 +: DW], 32'h11112222);
    chk("coll_conf_before", 32'(conf_b1), 32'd0);
    step();
    idle();
    @(negedge clk);
    chk("coll_conf_pulse", 32'(conf_b1), 32'd1);
    chk("coll_r7", rd_data_b0[0 +: DW], 32'h11112222);
    step();
    @(negedge clk);
    chk("coll_conf_drop", 32'(conf_b1), 32'd0);
    step();

    // bypass vs no bypass
    set_wr(0, 3, 32'h5, 4'hF);
    set_rd(0, 3);
    @(negedge clk);
    chk("byp_new", rd_data_b1[0 +: DW], 32'h5);
    chk("nobyp_old", rd_data_b0[0 +: DW], 32'h3);
    step();
    idle();
    @(negedge clk);
    chk("nobyp_after", rd_data_b0[0 +: DW], 32'h5);
    step();

    // zero register
    set_wr(0, 0, 32'hFFFFFFFF, 4'hF);
    set_wr(1, 0, 32'hFFFFFFFF, 4'hF);
    set_rd(0, 0);
    @(negedge clk);
    chk("r0_bypass", rd_data_b1[0 +: DW], 32'h0);
    step();
    idle();
    @(negedge clk);
    chk("r0_no_conf", 32'(conf_b1), 32'd0);
    chk("r0_read", rd_data_b0[0 +: DW], 32'h0);
    step();

    for (int i = 0; i < 400; i++) begin
      rand_cycle();
      step();
    end

    // mid-run reset
    idle();
    set_rd(0, 5);
    set_rd(1, 9);
    rst_n = 1'b0;
    #1;
    chk("rst_ready_async", 32'(ready_b1), 32'd0);
    chk("rst_rd_zero", rd_data_b1[0 +: DW], 32'h0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 33; c++) begin
      if (ready_b1) break;
      set_wr(0, 5, $urandom, 4'hF);
      set_wr(1, $urandom_range(1, DEPTH - 1), $urandom, 4'hF);
      @(negedge clk);
      chk("init_rd_zero", rd_data_b1[0 +: DW], 32'h0);
      step();
    end
    chk("refill_ready", 32'(ready_b1), 32'd1);
    idle();
    @(negedge clk);
    chk("refill_r5", rd_data_b1[0 +: DW], 32'd5);
    chk("refill_r9", rd_data_b1[DW +: DW], 32'd9);
    step();

    for (int i = 0; i < 200; i++) begin
      rand_cycle();
      step();
    end
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
